ne16_column_accumulator: RTL and testbench

Bit-serial partial-sum accumulator sitting directly downstream of one binconv column in the NE16 array. Consumes the column's signed per-bit-plane partial sums, scales each by its weight-bit significance (shift by plane index, MSB plane optionally negated for signed weights), and sums over all weight planes and all input-channel iterations. Emits one full-precision accumulation per output pixel/channel as a stream toward the accumulator/normquant stage.

---
 rtl/ne16_column_accumulator_pkg.sv | 29 ++
 rtl/ne16_column_accum_fsm.sv | 96 +++++++++
 rtl/ne16_column_accumulator.sv | 89 ++++++++
 tb/tb_ne16_column_accumulator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ne16_column_accumulator_pkg.sv
// Shared types and sizes for the NE16 column accumulator.
// Provides the control/flag structs, the FSM state enum and default widths
// for the column partial-sum input and the accumulator output.
package ne16_column_accumulator_pkg;

  localparam int NE16_ACC_WIDTH        = 32;
  localparam int NE16_COLUMN_PRES_SIZE = 16;
  localparam int NE16_ITER_WIDTH       = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } column_accum_state_t;

  typedef struct packed {
    logic [2:0]                 qw_m1;          // weight bit-planes minus 1
    logic [NE16_ITER_WIDTH-1:0] n_iter_m1;      // channel iterations minus 1
    logic                       signed_weights; // MSB plane carries negative weight
  } ctrl_column_accum_t;

  typedef struct packed {
    column_accum_state_t        state;
    logic                       busy;
    logic [2:0]                 bit_cnt;
    logic [NE16_ITER_WIDTH-1:0] iter_cnt;
  } flags_column_accum_t;

endpackage

// File: rtl/ne16_column_accum_fsm.sv
// Sequencer for the column accumulator: FSM, bit-plane / iteration counters
// and the latched control word.
// Ports: clk_i/rst_i (async active-high), enable_i stall, clear_i, start_i,
//   ctrl_i latched in IDLE, pres_valid_i / out_fire_i handshake inputs,
//   pres_ready_o, accept_o, negate_o, shift_o, last_o and flags_o to the datapath.
module ne16_column_accum_fsm
  import ne16_column_accumulator_pkg::*;
#(
  parameter int ITER_WIDTH = NE16_ITER_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  ctrl_column_accum_t  ctrl_i,
  input  logic                pres_valid_i,
  input  logic                out_fire_i,
  output logic                pres_ready_o,
  output logic                accept_o,
  output logic                negate_o,
  output logic [2:0]          shift_o,
  output logic                last_o,
  output flags_column_accum_t flags_o
);

  column_accum_state_t     r_state;
  ctrl_column_accum_t      r_ctrl;
  logic [2:0]              r_bit_cnt;
  logic [ITER_WIDTH-1:0]   r_iter_cnt;

  logic w_bit_last;
  logic w_iter_last;

  assign w_bit_last  = (r_bit_cnt == r_ctrl.qw_m1);
  assign w_iter_last = (r_iter_cnt == ITER_WIDTH'(r_ctrl.n_iter_m1));

  // Ready depends only on registered state so it never loops back on valid.
  assign pres_ready_o = enable_i && (r_state == ACCUM);
  // A clear in the same cycle wins over any beat that happens to be offered.
  assign accept_o     = pres_ready_o && pres_valid_i && !clear_i;
  assign negate_o     = r_ctrl.signed_weights && w_bit_last;
  assign shift_o      = r_bit_cnt;
  assign last_o       = w_bit_last && w_iter_last;

  assign flags_o.state    = r_state;
  assign flags_o.busy     = (r_state != IDLE);
  assign flags_o.bit_cnt  = r_bit_cnt;
  assign flags_o.iter_cnt = NE16_ITER_WIDTH'(r_iter_cnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_bit_cnt  <= '0;
      r_iter_cnt <= '0;
    end else if (clear_i) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_bit_cnt  <= '0;
      r_iter_cnt <= '0;
    end else if (enable_i) begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_ctrl     <= ctrl_i;
            r_bit_cnt  <= '0;
            r_iter_cnt <= '0;
            r_state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept_o) begin
            if (w_bit_last) begin
              r_bit_cnt <= '0;
              if (w_iter_last) begin
                r_iter_cnt <= '0;
                r_state    <= OUTPUT;
              end else begin
                r_iter_cnt <= r_iter_cnt + 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        OUTPUT: begin
          // Same latched ctrl is reused for the next pixel/channel.
          if (out_fire_i) r_state <= ACCUM;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ne16_column_accumulator.sv
// Bit-serial column accumulator: weights each signed bit-plane partial sum by
// its plane significance (MSB plane optionally negated) and sums over planes
// and channel iterations, emitting one ACC_WIDTH result per output.
// Ports: clk_i/rst_i (async active-high), enable_i, clear_i, start_i, ctrl_i,
//   column_pres_* sink stream, acc_* source stream (strb all ones), flags_o.
module ne16_column_accumulator
  import ne16_column_accumulator_pkg::*;
#(
  parameter int PRES_WIDTH = NE16_COLUMN_PRES_SIZE,
  parameter int ACC_WIDTH  = NE16_ACC_WIDTH,
  parameter int ITER_WIDTH = NE16_ITER_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic                   column_pres_valid_i,
  input  logic [PRES_WIDTH-1:0]  column_pres_data_i,
  output logic                   column_pres_ready_o,
  output logic                   acc_valid_o,
  output logic [ACC_WIDTH-1:0]   acc_data_o,
  output logic [ACC_WIDTH/8-1:0] acc_strb_o,
  input  logic                   acc_ready_i,
  input  ctrl_column_accum_t     ctrl_i,
  output flags_column_accum_t    flags_o
);

  logic                 w_accept;
  logic                 w_negate;
  logic [2:0]           w_shift;
  logic                 w_last;
  logic                 w_fire;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_term;
  logic [ACC_WIDTH-1:0] w_acc_next;

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_acc_valid;

  ne16_column_accum_fsm #(
    .ITER_WIDTH (ITER_WIDTH)
  ) i_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .ctrl_i       (ctrl_i),
    .pres_valid_i (column_pres_valid_i),
    .out_fire_i   (w_fire),
    .pres_ready_o (column_pres_ready_o),
    .accept_o     (w_accept),
    .negate_o     (w_negate),
    .shift_o      (w_shift),
    .last_o       (w_last),
    .flags_o      (flags_o)
  );

  // Output handshake only completes when enabled and not being cleared.
  assign w_fire = enable_i && r_acc_valid && acc_ready_i && !clear_i;

  // Sign-extend the plane partial sum, then scale by plane significance.
  // All arithmetic wraps modulo 2^ACC_WIDTH.
  assign w_ext      = {{(ACC_WIDTH-PRES_WIDTH){column_pres_data_i[PRES_WIDTH-1]}}, column_pres_data_i};
  assign w_term     = w_ext << w_shift;
  assign w_acc_next = w_negate ? (r_acc - w_term) : (r_acc + w_term);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
    end else if (clear_i) begin
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      if (w_last) r_acc_valid <= 1'b1;
    end else if (w_fire) begin
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
    end
  end

  assign acc_valid_o = r_acc_valid;
  assign acc_data_o  = r_acc;
  assign acc_strb_o  = '1;

endmodule

// File: tb/tb_ne16_column_accumulator.sv
// Bench for ne16_column_accumulator: directed vector table, hand-written
// corner sequences and randomized sessions against a plane-weighted sum model.
module tb_ne16_column_accumulator;
  import ne16_column_accumulator_pkg::*;

  localparam int PW = 16;
  localparam int AW = 32;

  logic                clk = 1'b0;
  logic                rst, enable, clear, start;
  logic                pv, pr, av, ar;
  logic [PW-1:0]       pd;
  logic [AW-1:0]       ad;
  logic [AW/8-1:0]     as;
  ctrl_column_accum_t  ctrl;
  flags_column_accum_t fl;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  ne16_column_accumulator #(
    .PRES_WIDTH (PW),
    .ACC_WIDTH  (AW),
    .ITER_WIDTH (16)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .enable_i            (enable),
    .clear_i             (clear),
    .start_i             (start),
    .column_pres_valid_i (pv),
    .column_pres_data_i  (pd),
    .column_pres_ready_o (pr),
    .acc_valid_o         (av),
    .acc_data_o          (ad),
    .acc_strb_o          (as),
    .acc_ready_i         (ar),
    .ctrl_i              (ctrl),
    .flags_o             (fl)
  );

  typedef struct packed {
    logic [2:0]       qw;
    logic [15:0]      nit;
    logic             sgn;
    logic [2:0]       nb;
    logic [3:0][15:0] beats;
    logic [31:0]      exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: every beat k lands on plane k mod (qw+1); each plane weighs
  // 2^plane, and the top plane is negative when weights are signed.
  function automatic logic [31:0] model(input int qw, input bit sgn, input int beats[$]);
    longint s = 0;
    foreach (beats[k]) begin
      int     p = k % (qw + 1);
      longint v = longint'(beats[k]) * (longint'(1) << p);
      if (sgn && p == qw) s -= v;
      else s += v;
    end
    return s[31:0];
  endfunction

  function automatic vec_t mk(input int qw, input int nit, input bit sgn, input int nb,
                              input int b0, input int b1, input int b2, input int b3,
                              input logic [31:0] exp);
    vec_t v;
    v.qw = 3'(qw); v.nit = 16'(nit); v.sgn = sgn; v.nb = 3'(nb);
    v.beats[0] = 16'(b0); v.beats[1] = 16'(b1); v.beats[2] = 16'(b2); v.beats[3] = 16'(b3);
    v.exp = exp;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge just after acceptance.
  task automatic send_beat(input logic [15:0] d);
    int n = 0;
    pv = 1'b1;
    pd = d;
    while (1) begin
      if (rand_mode) enable = ($urandom_range(0, 3) != 0);
      #1;
      if (pr) break;
      n++;
      if (n > 300) begin
        check("beat_timeout", 64'd0, 64'd1);
        pv = 1'b0;
        enable = 1'b1;
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
    pv = 1'b0;
    enable = 1'b1;
  endtask

  // Called at a negedge; returns the handshaken data at the negedge after it.
  task automatic take_output(output logic [31:0] got);
    int n = 0;
    got = '0;
    while (1) begin
      if (rand_mode) begin
        enable = ($urandom_range(0, 3) != 0);
        ar     = ($urandom_range(0, 1) != 0);
      end else begin
        ar = 1'b1;
      end
      #1;
      if (av && enable && ar) break;
      n++;
      if (n > 300) begin
        check("out_timeout", 64'd0, 64'd1);
        ar = 1'b0;
        enable = 1'b1;
        return;
      end
      @(negedge clk);
    end
    got = ad;
    @(negedge clk);
    ar = 1'b0;
    enable = 1'b1;
  endtask

  task automatic start_session(input int qw, input int nit, input bit sgn);
    enable = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ctrl.qw_m1 = 3'(qw);
    ctrl.n_iter_m1 = 16'(nit);
    ctrl.signed_weights = sgn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t        vecs[7];
  logic [31:0] got;

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0; start = 1'b0;
    pv = 1'b0; pd = '0; ar = 1'b0; ctrl = '0;

    #12;
    check("rst_valid", 64'(av), 64'd0);
    check("rst_data",  64'(ad), 64'd0);
    check("rst_strb",  64'(as), 64'hF);
    check("rst_ready", 64'(pr), 64'd0);
    check("rst_flags", 64'(fl), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = mk(0, 0, 0, 1,  5,  0, 0, 0, 32'd5);
    vecs[1] = mk(2, 0, 0, 3,  1,  1, 1, 0, 32'd7);
    vecs[2] = mk(2, 0, 0, 3, -1,  0, 3, 0, 32'd11);
    vecs[3] = mk(1, 0, 1, 2,  3,  1, 0, 0, 32'd1);
    vecs[4] = mk(0, 1, 0, 2, -4, 10, 0, 0, 32'd6);
    vecs[5] = mk(3, 0, 1, 4,  1,  1, 1, 1, 32'hFFFF_FFFF);
    vecs[6] = mk(1, 1, 1, 4,  5, -3, 2, 1, 32'd11);

    for (int i = 0; i < 7; i++) begin
      start_session(int'(vecs[i].qw), int'(vecs[i].nit), vecs[i].sgn);
      for (int j = 0; j < int'(vecs[i].nb); j++) send_beat(vecs[i].beats[j]);
      check("tbl_valid_lat1", 64'(av), 64'd1);
      check("tbl_ready_low",  64'(pr), 64'd0);
      take_output(got);
      check("tbl_data", 64'(got), 64'(vecs[i].exp));
      check("tbl_back_to_accum", 64'(fl.state), 64'(ACCUM));
    end

    // Signed weights: second output of the same session restarts from 0.
    start_session(1, 0, 1);
    send_beat(16'd3); send_beat(16'd1);
    take_output(got);
    check("sgn_out1", 64'(got), 64'd1);
    send_beat(16'd0); send_beat(16'd1);
    take_output(got);
    check("sgn_out2", 64'(got), 64'hFFFF_FFFE);

    // Output backpressure: data and valid held, input not ready.
    start_session(0, 1, 0);
    send_beat(-16'sd4); send_beat(16'd10);
    ar = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 64'(av), 64'd1);
      check("bp_data",  64'(ad), 64'd6);
      check("bp_ready", 64'(pr), 64'd0);
      @(negedge clk);
    end
    take_output(got);
    check("bp_handshake", 64'(got), 64'd6);

    // Clear after one of three beats, then a fresh session.
    start_session(2, 0, 0);
    send_beat(16'd7);
    check("clr_bitcnt", 64'(fl.bit_cnt), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_flags", 64'(fl), 64'd0);
    check("clr_data",  64'(ad), 64'd0);
    check("clr_valid", 64'(av), 64'd0);
    check("clr_ready", 64'(pr), 64'd0);
    start = 1'b1; ctrl = '0;
    @(negedge clk);
    start = 1'b0;
    send_beat(16'd9);
    take_output(got);
    check("clr_fresh", 64'(got), 64'd9);

    // Clear while OUTPUT with ready high: valid drops, no handshake.
    start_session(0, 0, 0);
    send_beat(16'd4);
    ar = 1'b1; clear = 1'b1;
    @(negedge clk);
    ar = 1'b0; clear = 1'b0;
    check("clrout_valid", 64'(av), 64'd0);
    check("clrout_state", 64'(fl.state), 64'(IDLE));

    // Enable low between beats, plus a start/ctrl change outside IDLE.
    start_session(3, 0, 0);
    ctrl.qw_m1 = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored", 64'(fl.state), 64'(ACCUM));
    send_beat(16'd1); send_beat(16'd2);
    pv = 1'b1; pd = 16'd3; enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("en_ready_low", 64'(pr), 64'd0);
      check("en_bit_frozen", 64'(fl.bit_cnt), 64'd2);
    end
    enable = 1'b1;
    send_beat(16'd3); send_beat(-16'sd1);
    take_output(got);
    check("en_sum", 64'(got), 64'(model(3, 1'b0, '{1, 2, 3, -1})));

    // Asynchronous reset while OUTPUT.
    start_session(0, 0, 0);
    send_beat(16'd3);
    check("rst_pre_valid", 64'(av), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(av), 64'd0);
    check("rst_async_data",  64'(ad), 64'd0);
    check("rst_async_flags", 64'(fl), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized sessions with random enable stalls and output backpressure.
    rand_mode = 1'b1;
    for (int s = 0; s < 12; s++) begin
      int qw  = int'($urandom_range(0, 7));
      int nit = int'($urandom_range(0, 2));
      bit sgn = ($urandom_range(0, 1) != 0);
      start_session(qw, nit, sgn);
      for (int o = 0; o < 2; o++) begin
        int q[$];
        q = {};
        for (int k = 0; k < (qw + 1) * (nit + 1); k++) begin
          int b = int'($urandom_range(0, 65535)) - 32768;
          q.push_back(b);
          send_beat(16'(b));
        end
        take_output(got);
        check("rand_out", 64'(got), 64'(model(qw, sgn, q)));
      end
    end
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
